mux_gate_sequencer: RTL

- Serial logic unit that time-shares one 2:1 mux cell to evaluate a bitwise logic op over a WIDTH-bit word, one bit per cycle.
- Each cycle the mux select is a[i], and its data inputs come from a per-op table, in the same way as the team's mux-built gate set.
- Sits between an operand source and a result consumer, with valid/ready handshakes on both sides.
- Serves as the sequenced, area-minimal counterpart of the parallel mux-gate block.

---
 rtl/mux_gate_pkg.sv | 43 ++++
 rtl/mux_gate_sequencer_mux2_cell.sv | 11 +
 rtl/mux_gate_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mux_gate_pkg.sv
// Shared definitions for the mux-built logic gate family: op codes, the
// sequencer state type, and the op -> mux data-input table.
package mux_gate_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Data inputs of the 2:1 mux: d0 is taken when the select (a bit) is 0,
    // d1 when it is 1.
    typedef struct packed {
        logic d0;
        logic d1;
    } mux_data_t;

    // Maps an op and one bit of operand B onto the mux data inputs so that
    // mux(sel=a_bit) yields the gate output for that bit. Illegal ops give 0.
    function automatic mux_data_t op_data(input logic [2:0] op, input logic b_bit);
        mux_data_t d;
        d.d0 = 1'b0;
        d.d1 = 1'b0;
        case (op)
            OP_AND:  begin d.d0 = 1'b0;   d.d1 = b_bit;  end
            OP_OR:   begin d.d0 = b_bit;  d.d1 = 1'b1;   end
            OP_NAND: begin d.d0 = 1'b1;   d.d1 = ~b_bit; end
            OP_NOR:  begin d.d0 = ~b_bit; d.d1 = 1'b0;   end
            OP_XOR:  begin d.d0 = b_bit;  d.d1 = ~b_bit; end
            OP_XNOR: begin d.d0 = ~b_bit; d.d1 = b_bit;  end
            default: begin d.d0 = 1'b0;   d.d1 = 1'b0;   end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mux_gate_sequencer_mux2_cell.sv
// Single 1-bit 2:1 mux cell; the only logic element used to form results.
module mux2_cell (
    input  logic s,
    input  logic d0,
    input  logic d1,
    output logic y
);

    assign y = (~s & d0) | (s & d1);

endmodule

// File: rtl/mux_gate_sequencer.sv
// Bit-serial logic unit: evaluates AND/OR/NAND/NOR/XOR/XNOR over a WIDTH-bit
// word one bit per cycle through a single shared 2:1 mux cell, with
// valid/ready handshakes on the request and result sides.
module mux_gate_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             err,
    output logic             busy
);
    import mux_gate_pkg::*;

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] y_reg;
    logic [2:0]       op_reg;
    logic             err_reg;
    logic [IW-1:0]    idx;

    logic             accept;
    logic             last_bit;
    logic             a_bit;
    logic             b_bit;
    logic             cell_y;
    mux_data_t        cell_d;
    logic [WIDTH-1:0] bit_mask;

    // Select the current bit of the captured operands and its mux data inputs.
    always_comb begin
        a_bit = 1'b0;
        b_bit = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (idx == IW'(i)) begin
                a_bit = a_reg[i];
                b_bit = b_reg[i];
            end
        end
        cell_d   = op_data(op_reg, b_bit);
        bit_mask = WIDTH'(1) << idx;
    end

    mux2_cell u_cell (
        .s  (a_bit),
        .d0 (cell_d.d0),
        .d1 (cell_d.d1),
        .y  (cell_y)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs; no input feeds an output directly.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_bit  = (idx == IW'(WIDTH - 1));
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture on accept, then one result bit written per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            op_reg  <= '0;
            y_reg   <= '0;
            err_reg <= 1'b0;
            idx     <= '0;
        end else if (accept) begin
            a_reg   <= a;
            b_reg   <= b;
            op_reg  <= op;
            y_reg   <= '0;
            err_reg <= (op > OP_XNOR);
            idx     <= '0;
        end else if (state == RUN) begin
            y_reg <= cell_y ? (y_reg | bit_mask) : (y_reg & ~bit_mask);
            idx   <= idx + 1'b1;
        end
    end

    assign y   = y_reg;
    assign err = err_reg;

endmodule
